// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: request opcodes, FSM states,
// access sizes and big-endian lane indices.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Big-endian: lane 0 is the most significant byte of the word.
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;
    localparam logic       HLANE_HI = 1'b0;
    localparam logic       HLANE_LO = 1'b1;

    function automatic size_e op_size(input op_e op);
        case (op)
            OP_LW, OP_SW:          return SZ_WORD;
            OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
            default:               return SZ_BYTE;
        endcase
    endfunction

    function automatic logic op_is_load(input op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_LH) || (op == OP_LB);
    endfunction

    function automatic logic op_misaligned(input op_e op, input logic [1:0] lo);
        case (op_size(op))
            SZ_WORD: return lo != 2'b00;
            SZ_HALF: return lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Lane steering shared by loads and stores: inserts store data into a word and
// extracts/extends a load value from a word, using big-endian lane numbering.
module mau_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic [31:0] store_data,
    input  logic        is_signed,
    output logic [31:0] merged_word,
    output logic [31:0] load_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged_word = store_data;
        load_value  = word;
        byte_sel    = word[7:0];
        half_sel    = word[15:0];
        case (size)
            SZ_BYTE: begin
                merged_word = word;
                case (lane)
                    LANE_0: begin byte_sel = word[31:24]; merged_word[31:24] = store_data[7:0]; end
                    LANE_1: begin byte_sel = word[23:16]; merged_word[23:16] = store_data[7:0]; end
                    LANE_2: begin byte_sel = word[15:8];  merged_word[15:8]  = store_data[7:0]; end
                    default: begin byte_sel = word[7:0];  merged_word[7:0]   = store_data[7:0]; end
                endcase
                load_value = {{24{is_signed & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged_word = word;
                // Only lane[1] matters; lane[0] is either trapped upstream or ignored.
                if (lane[1] == HLANE_HI) begin
                    half_sel           = word[31:16];
                    merged_word[31:16] = store_data[15:0];
                end else begin
                    half_sel           = word[15:0];
                    merged_word[15:0]  = store_data[15:0];
                end
                load_value = {{16{is_signed & half_sel[15]}}, half_sel};
            end
            default: begin
                merged_word = store_data;
                load_value  = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with read-modify-write for sub-word stores.
// Optional misalignment trapping is enabled by defining MEM_ALIGN_EXC_EN.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        exc_valid,
    output logic [31:0] exc_badvaddr,
    output logic        dm_w_enable,
    output logic [31:0] dm_address,
    output logic [31:0] dm_w_data,
    input  logic [31:0] dm_r_data
);

    state_e      state_p0;
    state_e      state_nxt;
    op_e         op;
    logic        accept;
    logic        mis;
    logic        is_load;
    logic        is_sub_store;
    logic [31:0] merged_word;
    logic [31:0] load_value;
    logic [31:0] merge_word_p1;
    logic [29:0] merge_addr_p1;

    assign op           = op_e'(req_op);
    assign accept       = req_valid && (state_p0 == ST_IDLE);
    assign is_load      = op_is_load(op);
    assign is_sub_store = (op == OP_SH) || (op == OP_SB);

`ifdef MEM_ALIGN_EXC_EN
    assign mis = op_misaligned(op, req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    // In IDLE the memory reads the requested word, so dm_r_data feeds both paths.
    mau_lane_merge u_lane_merge (
        .word        (dm_r_data),
        .lane        (req_addr[1:0]),
        .size        (op_size(op)),
        .store_data  (req_wdata),
        .is_signed   (op_is_signed(op)),
        .merged_word (merged_word),
        .load_value  (load_value)
    );

    always_comb begin
        state_nxt   = state_p0;
        req_ready   = 1'b0;
        dm_w_enable = 1'b0;
        dm_address  = {req_addr[31:2], 2'b00};
        dm_w_data   = req_wdata;
        case (state_p0)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !mis) begin
                    if (op == OP_SW)
                        dm_w_enable = 1'b1;
                    if (is_sub_store)
                        state_nxt = ST_RMW;
                end
            end
            ST_RMW: begin
                dm_w_enable = 1'b1;
                dm_address  = {merge_addr_p1, 2'b00};
                dm_w_data   = merge_word_p1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Memory writes on the same edge, so a write must never leak during reset.
        if (!rst_n)
            dm_w_enable = 1'b0;
    end

    // Stage p0 -> p1: FSM state, RMW latches and load result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0      <= ST_IDLE;
            ld_valid      <= 1'b0;
            ld_data       <= '0;
            merge_word_p1 <= '0;
            merge_addr_p1 <= '0;
        end else begin
            state_p0 <= state_nxt;
            ld_valid <= accept && is_load && !mis;
            if (accept && is_load && !mis)
                ld_data <= load_value;
            if (accept && is_sub_store && !mis) begin
                merge_word_p1 <= merged_word;
                merge_addr_p1 <= req_addr[31:2];
            end
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid    <= 1'b0;
            exc_badvaddr <= '0;
        end else begin
            exc_valid <= accept && mis;
            if (accept && mis)
                exc_badvaddr <= req_addr;
        end
    end
`else
    assign exc_valid    = 1'b0;
    assign exc_badvaddr = '0;
`endif

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit in the MEM stage, sitting directly upstream of the word-addressed data memory. Accepts one memory request per handshake from the EX/MEM boundary, generates word-aligned memory accesses, and performs read-modify-write for halfword/byte stores because the data memory only writes whole words. It extracts and extends load data, registers it for the MEM/WB boundary, and flags misaligned addresses.

## Interface
- No parameters; data and address width fixed at 32.
- `clk` in 1: single clock; data memory writes on the same rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle with `req_valid && req_ready`.
- `req_op` in 3: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for SB/SH.
- `ld_valid` out 1: one-cycle pulse; `ld_data` holds the new load result.
- `ld_data` out 32: extended load result, registered.
- `exc_valid` out 1: one-cycle pulse for an address error (only when the alignment macro is defined).
- `exc_badvaddr` out 32: faulting byte address, registered.
- `dm_w_enable` out 1: to data memory write enable.
- `dm_address` out 32: to data memory byte address; bits [1:0] are always 0.
- `dm_w_data` out 32: to data memory write data.
- `dm_r_data` in 32: from data memory; combinational read of `dm_address`.

## Operation
- Byte order is big-endian: byte lane 0 is bits [31:24] and lane 3 is bits [7:0]. Lane is `addr[1:0]`; halfword lane is `addr[1]`.
- FSM states:
  - IDLE: `req_ready`=1.
  - RMW: `req_ready`=0.
- IDLE, accepted load:
  - `dm_address` = `{req_addr[31:2],2'b00}`.
  - Lane selected from `dm_r_data`; LH/LB sign-extend, LHU/LBU zero-extend.
  - Registered into `ld_data` with `ld_valid`=1 next cycle. State stays IDLE.
- IDLE, accepted SW: `dm_w_enable`=1 the same cycle, `dm_w_data`=`req_wdata`. State stays IDLE.
- IDLE, accepted SH/SB:
  - Current word is read.
  - Merged word (selected lane replaced by the store data) and the word address are latched. Next state RMW.
- RMW:
  - Drive `dm_w_enable`=1 with the latched address and merged word; no request accepted.
  - Next state IDLE.
- Idle bus: `dm_address` follows `req_addr` aligned, and `dm_w_enable`=0 unless an SW is accepted.
- `dm_w_enable` is forced to 0 while `rst_n`=0.
- Misaligned request (macro defined):
  - Condition: LW/SW with `addr[1:0]`≠0, or LH/LHU/SH with `addr[0]`=1.
  - The request is accepted, causes no memory write and no `ld_valid`.
  - Next cycle `exc_valid`=1 and `exc_badvaddr`=`req_addr`. State stays IDLE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `ld_valid`=0, `ld_data`=0, `exc_valid`=0, `exc_badvaddr`=0, merge/address latches 0.
- Latencies:
  - Load: result one cycle after acceptance.
  - SW: written at the acceptance edge.
  - SH/SB: written at the edge ending RMW, two edges after acceptance; throughput one per 2 cycles.
- Ordering:
  - A request presented during RMW is held off by `req_ready`=0 and must be held stable upstream.
  - A load to the same word directly after SH/SB returns the merged value.
- `ld_valid` and `exc_valid` are never both 1. `ld_data` and `exc_badvaddr` hold their values between pulses.
- Reset during RMW: the pending write is discarded, the state returns to IDLE, and `dm_w_enable` drops immediately.

## Configuration
- `MEM_ALIGN_EXC_EN` defined: misalignment detection and `exc_valid`/`exc_badvaddr` behave as above.
- Not defined:
  - `exc_valid` and `exc_badvaddr` are tied to 0.
  - Low address bits beyond the access size are ignored: LW/SW use the word, LH/LHU/SH use lane `addr[1]`.
  - All requests execute normally.

## Structure
- Package `mem_access_pkg`: `req_op` encodings, FSM state encoding, lane-index constants.
- Sub-module `mau_lane_merge`: combinational; given word, lane, size and store data, produces the merged store word, and given word, lane, size and signedness, produces the extended load value. It is instantiated once and shared by the load and store paths.

## Test plan
- Reset, then LW @0x10 with memory word 0x11223344 → `ld_valid` one cycle later, `ld_data`=0x11223344, `dm_w_enable` never high.
- LB @0x13 on word 0x112233F4 → `ld_data`=0xFFFFFFF4; LBU same address → 0x000000F4; LH @0x12 → 0x000033F4.
- SB @0x11 data 0xAB onto 0x11223344 → `req_ready`=0 for one cycle, write of 0x11AB3344 at the RMW edge; back-to-back LW @0x10 → 0x11AB3344.
- SW @0x20 data 0xDEADBEEF followed immediately by SH @0x22 data 0x1234 → memory word 0xDEAD1234, with SW written at the acceptance edge.
- With `MEM_ALIGN_EXC_EN`: LW @0x21 → `exc_valid` pulse, `exc_badvaddr`=0x21, no `ld_valid`; SH @0x23 → exception and memory unchanged. Without the macro, LW @0x21 returns the word at 0x20.
- Assert `rst_n`=0 during RMW of SB @0x30 → no write occurs, outputs reach their reset values, and `req_ready`=1 after release.
